// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default result/tag widths and CDB source encoding.
package tomasulo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int TAG_W_DEF  = 3;

    typedef enum logic {
        SRC_ADD = 1'b0,
        SRC_MUL = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result queue; head visible the cycle after push, pointers wrap mod DEPTH.
// Backpressure: full flag derived from count only; caller must not push when full or pop when empty.
module cdb_fifo #(
    parameter int DW    = 11,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign head_dat = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin ADD/MUL result arbiter onto a registered CDB; 2 edges accept-to-broadcast, x_ready = !full, CDB never stalls.
// Optional per-source saturating broadcast counters under CDB_STATS_EN.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TAG_W      = TAG_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_valid,
    input  logic [DATA_W-1:0] add_data,
    input  logic [TAG_W-1:0]  add_tag,
    output logic              add_ready,
    input  logic              mul_valid,
    input  logic [DATA_W-1:0] mul_data,
    input  logic [TAG_W-1:0]  mul_tag,
    output logic              mul_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic              cdb_src
`ifdef CDB_STATS_EN
    ,
    output logic [7:0]        add_bcast_cnt,
    output logic [7:0]        mul_bcast_cnt
`endif
);

    localparam int EW = DATA_W + TAG_W;

    logic          add_full, add_empty, mul_full, mul_empty;
    logic [EW-1:0] add_head, mul_head;
    logic          gnt_add, gnt_mul;

    src_e              last_q, last_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    src_e              cdb_src_q, cdb_src_d;

    assign add_ready = !add_full;
    assign mul_ready = !mul_full;

    cdb_fifo #(.DW(EW), .DEPTH(FIFO_DEPTH)) u_add_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (add_valid && add_ready),
        .push_dat ({add_tag, add_data}),
        .pop      (gnt_add),
        .head_dat (add_head),
        .empty    (add_empty),
        .full     (add_full)
    );

    cdb_fifo #(.DW(EW), .DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mul_valid && mul_ready),
        .push_dat ({mul_tag, mul_data}),
        .pop      (gnt_mul),
        .head_dat (mul_head),
        .empty    (mul_empty),
        .full     (mul_full)
    );

    always_comb begin
        gnt_add     = 1'b0;
        gnt_mul     = 1'b0;
        last_d      = last_q;
        cdb_valid_d = 1'b0;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        // On a tie the source that lost last time wins.
        if (!add_empty && !mul_empty) begin
            if (last_q == SRC_MUL) gnt_add = 1'b1;
            else                   gnt_mul = 1'b1;
        end else if (!add_empty) begin
            gnt_add = 1'b1;
        end else if (!mul_empty) begin
            gnt_mul = 1'b1;
        end
        if (gnt_add) begin
            last_d                 = SRC_ADD;
            cdb_valid_d            = 1'b1;
            {cdb_tag_d, cdb_data_d} = add_head;
            cdb_src_d              = SRC_ADD;
        end else if (gnt_mul) begin
            last_d                 = SRC_MUL;
            cdb_valid_d            = 1'b1;
            {cdb_tag_d, cdb_data_d} = mul_head;
            cdb_src_d              = SRC_MUL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= SRC_MUL;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= SRC_ADD;
        end else begin
            last_q      <= last_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_src   = cdb_src_q;

`ifdef CDB_STATS_EN
    logic [7:0] add_cnt_q, add_cnt_d;
    logic [7:0] mul_cnt_q, mul_cnt_d;

    always_comb begin
        add_cnt_d = add_cnt_q;
        mul_cnt_d = mul_cnt_q;
        if (gnt_add && add_cnt_q != 8'hFF) add_cnt_d = add_cnt_q + 8'd1;
        if (gnt_mul && mul_cnt_q != 8'hFF) mul_cnt_d = mul_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_cnt_q <= '0;
            mul_cnt_q <= '0;
        end else begin
            add_cnt_q <= add_cnt_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    assign add_bcast_cnt = add_cnt_q;
    assign mul_bcast_cnt = mul_cnt_q;
`endif

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, result data width.
REQ-002 SHALL have parameter TAG_W, default 3, reservation-station tag width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, entries per source queue (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port add_valid  input  1  ADD unit result valid.
REQ-007 SHALL have port add_data  input  DATA_W  ADD unit result.
REQ-008 SHALL have port add_tag  input  TAG_W  ADD result tag.
REQ-009 SHALL have port add_ready  output  1  ADD queue can accept.
REQ-010 SHALL have ports mul_valid, mul_data, mul_tag, mul_ready with the same directions, widths and meanings for the MUL unit.
REQ-011 SHALL have port cdb_valid  output  1  common data bus broadcast valid.
REQ-012 SHALL have port cdb_data  output  DATA_W  broadcast result.
REQ-013 SHALL have port cdb_tag  output  TAG_W  broadcast tag.
REQ-014 SHALL have port cdb_src  output  1  broadcast source, 0=ADD, 1=MUL.

Function
REQ-015 SHALL queue each source in its own FIFO of FIFO_DEPTH entries (data+tag).
REQ-016 SHALL push a source entry on any rising edge where valid && ready; valid without ready is ignored, not held.
REQ-017 SHALL drive x_ready = !full combinationally from queue count only (no dependence on x_valid).
REQ-018 SHALL allow simultaneous push and pop on one queue in a cycle; count unchanged.
REQ-019 SHALL grant at most one non-empty queue per cycle; the granted head is popped on that edge.
REQ-020 SHALL use round-robin: if both queues are non-empty, grant the source not granted last; if one is non-empty, grant it and update last-grant.
REQ-021 SHALL register the CDB outputs: a granted entry appears on cdb_* for exactly one cycle after the grant edge.
REQ-022 SHALL give latency of 2 edges from acceptance to broadcast: entry accepted at edge E is visible on cdb_valid after edge E+1 when uncontended; no input-to-CDB bypass.
REQ-023 SHALL deassert cdb_valid in any cycle with no grant; cdb_data/cdb_tag/cdb_src hold their last values.
REQ-024 SHALL apply no CDB back-pressure; broadcasts are never stalled.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH with a separate count of width log2(FIFO_DEPTH)+1.

Reset
REQ-026 SHALL on rst clear both queues, set cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_src=0, last-grant=MUL (ADD wins first tie).
REQ-027 SHALL discard in-flight queue entries when rst asserts mid-operation; add_ready=mul_ready=1 while rst is asserted.

Configuration
REQ-028 SHALL, with CDB_STATS_EN defined, add outputs add_bcast_cnt and mul_bcast_cnt (8 bits each, saturating at 255, reset 0) counting broadcasts per source.
REQ-029 SHALL, without CDB_STATS_EN, have neither the counters nor their ports; behaviour otherwise identical.

Structure
REQ-030 SHALL place the DATA_W/TAG_W defaults and the source encoding (SRC_ADD=0, SRC_MUL=1) in shared package tomasulo_pkg.
REQ-031 SHALL implement the per-source queue as sub-module cdb_fifo, instantiated twice.

Verification
REQ-032 SHALL cover single ADD: add_valid 1 cycle, data 8'h15, tag 3'd2 -> cdb_valid=1, cdb_data=8'h15, cdb_tag=2, cdb_src=0 after edge E+1.
REQ-033 SHALL cover tie: ADD (8'h0A, tag 1) and MUL (8'h30, tag 5) accepted on the same edge after reset -> ADD broadcast first, MUL on the next cycle.
REQ-034 SHALL cover fairness: both sources valid every cycle for 8 cycles -> broadcasts strictly alternate ADD/MUL, no cdb_valid gaps after the first.
REQ-035 SHALL cover full: MUL valid 4 consecutive cycles, ADD queue feeding continuously -> mul_ready drops to 0 when the MUL queue holds 2 entries; no entry lost or duplicated.
REQ-036 SHALL cover reset mid-operation: rst asserted with both queues holding 2 entries -> cdb_valid=0 immediately; no stale broadcast after rst release.
REQ-037 SHALL cover CDB_STATS_EN: 300 ADD broadcasts -> add_bcast_cnt=255 (saturated), mul_bcast_cnt=0.
